// File: rtl/puzzle_pkg.sv
// Shared definitions for the button-sequence puzzle.
//   state_e    : puzzle FSM states
//   LFSR_SEED  : value the LFSR restarts from on reset
//   LFSR_TAPS  : feedback taps of x^16+x^14+x^13+x^11+1 in right-shift form
//                (bits 0, 2, 3, 5 of the register)
//   onehot4    : 2-bit button index -> one-hot LED/button pattern
//   thermo4    : count of correct presses -> progress thermometer
package puzzle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHOW   = 3'd1,
    ST_GAP    = 3'd2,
    ST_INPUT  = 3'd3,
    ST_SOLVED = 3'd4
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // led[j] = 1 for every j below k
  function automatic logic [3:0] thermo4(input logic [1:0] k);
    case (k)
      2'd0:    return 4'b0000;
      2'd1:    return 4'b0001;
      2'd2:    return 4'b0011;
      default: return 4'b0111;
    endcase
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the puzzle's randomness source.
//   clk : clock
//   rst : synchronous active-high reset, loads LFSR_SEED
//   q   : current register value
// Shifts right every non-reset cycle; the XOR of the tapped bits enters at b15.
module lfsr16
  import puzzle_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic        fb;

  assign fb = ^(lfsr_q & LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= {fb, lfsr_q[15:1]};
  end

  assign q = lfsr_q;

endmodule

// File: rtl/btn_sequence_puzzle.sv
// Memory-game puzzle guarding the alarm: plays back a short random button
// sequence on the LEDs, then waits for the user to repeat it.
//   clk      : clock
//   rst      : synchronous active-high reset
//   btn_dn   : one-cycle press pulses, bit i = button i
//   alarm_on : level, high while the puzzle must be solved
//   led      : one-hot step during playback, progress thermometer during
//              input, all-on for the solved cycle
//   solved   : registered one-cycle pulse on a correct full entry
//   fail     : registered one-cycle pulse on a wrong press or a timeout
//   busy     : high whenever the FSM is out of IDLE
// The sequence is 8 bits: step k is the button index in seq[2k+1:2k].
module btn_sequence_puzzle
  import puzzle_pkg::*;
#(
  parameter int SEQ_LEN        = 4,
  parameter int SHOW_CYCLES    = 25_000_000,
  parameter int GAP_CYCLES     = 12_500_000,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_dn,
  input  logic       alarm_on,
  output logic [3:0] led,
  output logic       solved,
  output logic       fail,
  output logic       busy
);

  // One shared cycle counter serves SHOW, GAP and the input timeout; it only
  // ever needs to hold (largest period - 1).
  localparam int MAX_SG = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int MAX_T  = (MAX_SG > TIMEOUT_CYCLES) ? MAX_SG : TIMEOUT_CYCLES;
  localparam int CW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    STEP_LAST = 2'(SEQ_LEN - 1);

  state_e          state_q, state_d;
  logic [7:0]      seq_q, seq_d;
  logic [1:0]      step_q, step_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      fcnt_q, fcnt_d;
  logic            solved_q, solved_d;
  logic            fail_q, fail_d;

  logic [15:0]     lfsr_q;
  logic            lfsr_unused;
  logic [3:0]      cur_oh;
  logic            last_step;

  lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  // Only the low byte seeds a puzzle.
  assign lfsr_unused = ^lfsr_q[15:8];

  assign cur_oh    = onehot4(seq_q[{step_q, 1'b0} +: 2]);
  assign last_step = (step_q == STEP_LAST);

  always_comb begin
    state_d  = state_q;
    seq_d    = seq_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    fcnt_d   = fcnt_q;
    solved_d = 1'b0;
    fail_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (alarm_on) begin
          seq_d   = lfsr_q[7:0];
          step_d  = 2'd0;
          cnt_d   = '0;
          fcnt_d  = 2'd0;
          state_d = ST_SHOW;
        end
      end

      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (last_step) begin
            step_d  = 2'd0;
            state_d = ST_INPUT;
          end else begin
            step_d  = step_q + 2'd1;
            state_d = ST_SHOW;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_INPUT: begin
        if (btn_dn == cur_oh) begin
          cnt_d = '0;
          if (last_step) begin
            step_d   = 2'd0;
            solved_d = 1'b1;
            state_d  = ST_SOLVED;
          end else begin
            step_d = step_q + 2'd1;
          end
        end else if (btn_dn != 4'd0 || cnt_q == TO_LAST) begin
          // Wrong button, chord, or timeout: replay from step 0. The fail
          // count is only cleared by a new puzzle, so a correct press in
          // between does not break the run of fails.
          fail_d  = 1'b1;
          cnt_d   = '0;
          step_d  = 2'd0;
          state_d = ST_SHOW;
          if (fcnt_q == 2'd2) begin
            seq_d  = lfsr_q[7:0];
            fcnt_d = 2'd0;
          end else begin
            fcnt_d = fcnt_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SOLVED: begin
        step_d  = 2'd0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end

      default: begin
        step_d  = 2'd0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Alarm cleared externally: abandon whatever was in progress silently.
    if (!alarm_on && state_q != ST_SOLVED) begin
      state_d  = ST_IDLE;
      seq_d    = seq_q;
      fcnt_d   = fcnt_q;
      step_d   = 2'd0;
      cnt_d    = '0;
      solved_d = 1'b0;
      fail_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      seq_q    <= 8'd0;
      step_q   <= 2'd0;
      cnt_q    <= '0;
      fcnt_q   <= 2'd0;
      solved_q <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      seq_q    <= seq_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      fcnt_q   <= fcnt_d;
      solved_q <= solved_d;
      fail_q   <= fail_d;
    end
  end

  // LED is a pure decode of registered state, so it cannot glitch on inputs.
  always_comb begin
    led = 4'd0;
    case (state_q)
      ST_SHOW:   led = cur_oh;
      ST_INPUT:  led = thermo4(step_q);
      ST_SOLVED: led = 4'hF;
      default:   led = 4'd0;
    endcase
  end

  assign solved = solved_q;
  assign fail   = fail_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_btn_sequence_puzzle.sv
// Self-checking bench for btn_sequence_puzzle (SEQ_LEN=4, SHOW=4, GAP=2,
// TIMEOUT=20). Stimulus tasks walk the puzzle rules at the transaction level
// and queue the expected outputs for every cycle; a negedge monitor pops and
// compares independently.
module tb_btn_sequence_puzzle;

  localparam int SEQ_LEN = 4;
  localparam int SHOW    = 4;
  localparam int GAP     = 2;
  localparam int TO      = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_dn;
  logic       alarm_on;
  logic [3:0] led;
  logic       solved;
  logic       fail;
  logic       busy;

  always #5 clk = ~clk;

  btn_sequence_puzzle #(
    .SEQ_LEN        (SEQ_LEN),
    .SHOW_CYCLES    (SHOW),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_dn   (btn_dn),
    .alarm_on (alarm_on),
    .led      (led),
    .solved   (solved),
    .fail     (fail),
    .busy     (busy)
  );

  typedef struct {
    logic [3:0] led;
    logic       sol;
    logic       fl;
    logic       bsy;
    int         sc;
  } exp_t;

  exp_t exp_q[$];
  int   nvec = 0;
  int   nmis = 0;
  int   scen = 0;

  // ---------------- reference model state ----------------
  logic [15:0] lfsr_m;    // value the DUT's LFSR holds during the current cycle
  logic [7:0]  seq;
  int          fcnt;
  int          k;         // correct presses so far in this attempt
  int          idle;      // consecutive no-press cycles in the input phase
  bit          solved_f;
  bit          fail_f;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    // x^16+x^14+x^13+x^11+1, right shift, feedback into b15
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  function automatic logic [3:0] want_btn(input int kk);
    return 4'(1 << ((int'(seq) >> (2 * kk)) & 3));
  endfunction

  function automatic logic [3:0] therm(input int kk);
    return 4'((1 << kk) - 1);
  endfunction

  function automatic logic [3:0] noise();
    return 4'($urandom_range(0, 15));
  endfunction

  // Drive one cycle: e_* are the outputs expected during this cycle.
  task automatic cyc(input logic [3:0] e_led, input logic e_sol, input logic e_fl,
                     input logic e_bsy, input logic [3:0] b, input logic a,
                     input logic r);
    exp_t e;
    btn_dn   = b;
    alarm_on = a;
    rst      = r;
    e.led = e_led; e.sol = e_sol; e.fl = e_fl; e.bsy = e_bsy; e.sc = scen;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    lfsr_m = r ? 16'hACE1 : lfsr_next(lfsr_m);
  endtask

  // Playback of the whole sequence; drop_at >= 0 lowers alarm_on on that
  // cycle of the playback and lets the puzzle fall back to IDLE.
  task automatic playback(input bit fl_first, input int drop_at);
    logic [3:0] pl[$];
    for (int s = 0; s < SEQ_LEN; s++) begin
      repeat (SHOW) pl.push_back(want_btn(s));
      repeat (GAP)  pl.push_back(4'd0);
    end
    for (int i = 0; i < pl.size(); i++) begin
      if (i == drop_at) begin
        cyc(pl[i], 1'b0, fl_first && i == 0, 1'b1, noise(), 1'b0, 1'b0);
        cyc(4'd0, 1'b0, 1'b0, 1'b0, noise(), 1'b0, 1'b0);
        break;
      end
      cyc(pl[i], 1'b0, fl_first && i == 0, 1'b1, noise(), 1'b1, 1'b0);
    end
    k    = 0;
    idle = 0;
  endtask

  // One IDLE cycle with alarm_on high starts a fresh puzzle.
  task automatic start(input int drop_at);
    seq  = lfsr_m[7:0];
    fcnt = 0;
    cyc(4'd0, 1'b0, 1'b0, 1'b0, noise(), 1'b1, 1'b0);
    playback(1'b0, drop_at);
  endtask

  task automatic fail_event(input logic [3:0] b);
    fcnt++;
    if (fcnt == 3) begin
      seq  = lfsr_m[7:0];
      fcnt = 0;
    end
    cyc(therm(k), 1'b0, 1'b0, 1'b1, b, 1'b1, 1'b0);
    fail_f = 1'b1;
    playback(1'b1, -1);
  endtask

  task automatic idle_input();
    if (idle == TO - 1) fail_event(4'd0);
    else begin
      cyc(therm(k), 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
      idle++;
    end
  endtask

  task automatic press(input logic [3:0] b);
    if (b == 4'd0) idle_input();
    else if (b == want_btn(k)) begin
      cyc(therm(k), 1'b0, 1'b0, 1'b1, b, 1'b1, 1'b0);
      idle = 0;
      k++;
      if (k == SEQ_LEN) begin
        cyc(4'hF, 1'b1, 1'b0, 1'b1, noise(), 1'b1, 1'b0);
        solved_f = 1'b1;
      end
    end else fail_event(b);
  endtask

  task automatic wrong_press();
    logic [3:0] b;
    b = 4'($urandom_range(1, 15));
    while (b == want_btn(k)) b = 4'($urandom_range(1, 15));
    press(b);
  endtask

  task automatic drop_in_input();
    cyc(therm(k), 1'b0, 1'b0, 1'b1, noise(), 1'b0, 1'b0);
    cyc(4'd0, 1'b0, 1'b0, 1'b0, noise(), 1'b0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (solved === 1'b1 && fail === 1'b1) begin
      nmis++;
      $display("FAIL t=%0t: solved and fail high together", $time);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      nvec++;
      if (led !== e.led || solved !== e.sol || fail !== e.fl || busy !== e.bsy) begin
        nmis++;
        $display("FAIL scen%0d t=%0t: got led=%h solved=%b fail=%b busy=%b, want led=%h solved=%b fail=%b busy=%b",
                 e.sc, $time, led, solved, fail, busy, e.led, e.sol, e.fl, e.bsy);
      end
    end
  end

  initial begin
    #600_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    alarm_on = 1'b1;
    btn_dn   = 4'd0;
    solved_f = 1'b0;
    fail_f   = 1'b0;
    k = 0; idle = 0; fcnt = 0; seq = 8'd0;
    @(posedge clk);
    #1;
    lfsr_m = 16'hACE1;

    // reset values with alarm_on held high
    scen = 1;
    cyc(4'd0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b1);

    // first puzzle after reset plays seed byte E1: buttons 1,0,2,3
    scen = 2;
    start(-1);
    press(4'b0010);
    repeat (2) idle_input();
    press(4'b0001);
    idle_input();
    press(4'b0100);
    press(4'b1000);

    // correct then wrong press -> fail and replay; then a chord at step 0
    scen = 3;
    start(-1);
    press(want_btn(0));
    wrong_press();
    scen = 4;
    press(4'b0011 == want_btn(0) ? 4'b0101 : 4'b0011);
    drop_in_input();

    // alarm dropped mid-GAP
    scen = 5;
    start(SHOW + 1);

    // three timeouts -> reseed and replay of the new sequence
    scen = 6;
    start(-1);
    for (int t = 0; t < 3; t++) begin
      fail_f = 1'b0;
      while (!fail_f) idle_input();
    end
    press(want_btn(0));

    // reset in the middle of the input phase
    scen = 7;
    cyc(therm(k), 1'b0, 1'b0, 1'b1, noise(), 1'b1, 1'b1);
    cyc(4'd0, 1'b0, 1'b0, 1'b0, noise(), 1'b1, 1'b1);

    // randomized rounds
    for (int r = 0; r < 8; r++) begin
      int acts;
      int roll;
      scen     = 10 + r;
      acts     = 0;
      solved_f = 1'b0;
      start(-1);
      while (!solved_f && acts < 60) begin
        acts++;
        roll = $urandom_range(0, 99);
        if (roll < 75) begin
          repeat ($urandom_range(0, 3)) idle_input();
          press(want_btn(k));
        end else if (roll < 92) begin
          wrong_press();
        end else begin
          fail_f = 1'b0;
          while (!fail_f) idle_input();
        end
      end
      if (!solved_f) drop_in_input();
    end

    cyc(4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    if (nvec == 0) begin
      nmis++;
      $display("FAIL no vectors were checked");
    end
    if (nmis != 0) $fatal(1, "FAIL %0d miscompares", nmis);
    else $display("PASS");
    $finish;
  end

endmodule

// File: doc/btn_sequence_puzzle.md
BTN_SEQUENCE_PUZZLE -- requirements
Module: btn_sequence_puzzle

Interface
REQ-001 SHALL have parameter SEQ_LEN, default 4: number of button steps per puzzle, max 4.
REQ-002 SHALL have parameter SHOW_CYCLES, default 25_000_000: LED-on time per step during playback.
REQ-003 SHALL have parameter GAP_CYCLES, default 12_500_000: LED-off time after each playback step.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 500_000_000: maximum idle time between presses in the input phase.
REQ-005 SHALL have port clk, input, 1: clock.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port btn_dn, input, 4: one-cycle press pulses from the debouncers; bit i = button i.
REQ-008 SHALL have port alarm_on, input, 1: level from the alarm block; high means the puzzle must be solved.
REQ-009 SHALL have port led, output, 4: playback and progress display.
REQ-010 SHALL have port solved, output, 1: one-cycle pulse when the sequence is entered correctly.
REQ-011 SHALL have port fail, output, 1: one-cycle pulse on a wrong press or timeout.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-013 SHALL run a 16-bit Fibonacci LFSR: polynomial x^16+x^14+x^13+x^11+1; feedback = b0^b2^b3^b5; right shift, feedback into b15; advances on every non-reset cycle.
REQ-014 SHALL implement states IDLE, SHOW, GAP, INPUT, SOLVED.
REQ-015 IDLE: when alarm_on = 1, SHALL capture seq[7:0] = lfsr[7:0] (current register value), clear step and fail_cnt, go to SHOW.
REQ-016 Step k SHALL be button seq[2k+1:2k], k = 0..SEQ_LEN-1.
REQ-017 SHOW: led = one-hot of step k for exactly SHOW_CYCLES cycles, then GAP.
REQ-018 GAP: led = 0 for exactly GAP_CYCLES cycles. Then SHALL go to SHOW with k+1, or to INPUT with k=0 after the last step.
REQ-019 INPUT: led = thermometer of correct presses so far (led[j] = 1 for j < k).
REQ-020 INPUT: btn_dn equal to one-hot of step k SHALL count as a correct press: k increments and the timeout counter clears.
REQ-021 INPUT: a correct press on the last step SHALL go to SOLVED.
REQ-022 INPUT: any other nonzero btn_dn, including multiple bits set in one cycle, SHALL count as a wrong press: fail pulses, fail_cnt increments, k=0, next state SHOW (replay).
REQ-023 INPUT: timeout counter reaching TIMEOUT_CYCLES with no press SHALL act as a wrong press.
REQ-024 On the third consecutive fail, SHALL load a new seq from the current lfsr[7:0] and clear fail_cnt before replay.
REQ-025 SOLVED: one cycle, solved = 1, led = 4'hF; next state IDLE.
REQ-026 btn_dn SHALL be ignored in IDLE, SHOW, GAP and SOLVED.
REQ-027 alarm_on = 0 in any state other than SOLVED SHALL force IDLE next cycle, with led = 0 and no pulses.
REQ-028 solved and fail SHALL be registered outputs, never high in the same cycle.

Reset
REQ-029 On rst SHALL set: state = IDLE, lfsr = 16'hACE1, seq = 0, all counters = 0, led = 0, solved = 0, fail = 0, busy = 0.
REQ-030 rst SHALL override all other inputs in the same cycle, including mid-playback and mid-input.

Structure
REQ-031 Package puzzle_pkg SHALL hold the state enum, LFSR_SEED = 16'hACE1 and the LFSR tap mask.
REQ-032 SHALL use sub-module lfsr16: ports clk, rst, q[15:0].
REQ-033 Cycle counters SHALL be sized by $clog2 of the largest timing parameter.

Verification
Use SEQ_LEN=4, SHOW=4, GAP=2, TIMEOUT=20 in all scenarios.
REQ-034 alarm_on high on the first cycle after rst -> seq = 8'hE1; led shows 2, 1, 4, 8, each for 4 cycles with 2 cycles of 0 between.
REQ-035 Input presses 1, 0, 2, 3 -> led steps 1, 3, 7; solved pulses once with led = F; then IDLE and busy = 0.
REQ-036 Press 1, then press 2 -> fail pulse; replay starts with led = 2; thermometer cleared.
REQ-037 No press for 20 cycles in INPUT -> fail pulse; three such timeouts -> a new seq is loaded and played back.
REQ-038 btn_dn = 4'b0011 at step 0 -> fail; any btn_dn during SHOW/GAP -> no effect.
REQ-039 alarm_on dropped mid-GAP -> IDLE next cycle; rst asserted mid-INPUT -> all reset values from REQ-029.
